simon_ti3_serial_core: RTL and testbench
========================================

Name: simon_ti3_serial_core

Overview:
- Parametrised successor of the 3-share threshold-implementation (TI) bit-serial Simon datapath.
- Generalised to any Simon word size N and round count, with its own load/run/unload control FSM and valid/ready handshakes on data, round key and ciphertext.
- Each of the three shares streams 1 bit/cycle.
- Sits between the share-generating plaintext loader, the TI key-schedule block and the ciphertext recombiner.

Parameters:
- N, 64, word size in bits; legal 16, 24, 32, 48, 64 (block = 2N).
- ROUNDS, 68, number of Simon rounds.
- RW, $clog2(ROUNDS), round index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin an operation; sampled only in IDLE.
- din_a, din_b, din_c  in  1 each  plaintext share bits.
- din_valid  in  1  qualifies din_*.
- din_ready  out  1  high in LOAD.
- key_a, key_b, key_c  in  1 each  round-key share bits, LSB first per round.
- key_valid  in  1  qualifies key_*.
- key_ready  out  1  high in RUN.
- ct_a, ct_b, ct_c  out  1 each  ciphertext share bits.
- ct_valid  out  1  qualifies ct_*.
- ct_ready  in  1  downstream accepts ct_*.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse, coincident with the last accepted ct bit.
- round_idx  out  RW  current round (0..ROUNDS-1); 0 outside RUN.

Behaviour:
- State per share: x_s, y_s, N bits each. Unmasked value = a^b^c.
- FSM states: IDLE, LOAD, RUN, UNLOAD.
- Reset (rst_n=0 at a clk edge), regardless of state:
  - state -> IDLE; bit counter, round_idx and all share registers -> 0.
  - busy, done, ct_valid, din_ready, key_ready, ct_* = 0.
- IDLE:
  - start=1 -> LOAD on the next cycle.
  - start in any other state is ignored.
- LOAD:
  - One bit per share accepted per cycle with din_valid & din_ready.
  - Order: y LSB..MSB (N bits), then x LSB..MSB (N bits).
  - din_valid=0 stalls without losing position.
  - After the 2N-th accepted bit -> RUN with round_idx=0.
- RUN:
  - A step occurs on cycles with key_valid & key_ready; the datapath is frozen otherwise.
  - Step i (0..N-1) of round r consumes key bit i and produces new-x bit i per share.
  - Rotation operands (i-1, i-2, i-8 mod N) read from the pre-round x; wrap-around handled internally.
  - TI share function (s = a, b, c; s' and s'' are the next two shares cyclically):
    - x'_s[i] = y_s'[i] ^ k_s'[i] ^ S2x_s'[i] ^ (S1x_s'[i]&S8x_s'[i]) ^ (S1x_s'[i]&S8x_s''[i]) ^ (S1x_s''[i]&S8x_s'[i])
    - Sk·x[i] = x[(i-k) mod N].
    - Non-complete: no output share uses its own index.
  - After step N-1: y_s <= old x_s, x_s <= x'_s, round_idx += 1.
  - After round ROUNDS-1 -> UNLOAD; round_idx returns to 0.
  - Minimum RUN duration is ROUNDS*N cycles.
- UNLOAD:
  - ct_valid=1; same bit order as LOAD (y then x, LSB first).
  - A bit advances only on ct_valid & ct_ready; ct_* are held stable while ct_ready=0.
  - done=1 in the cycle the 2N-th bit is accepted.
  - Next cycle: IDLE, busy=0. start in that IDLE cycle is honoured normally.
- No-stall latency from start: 1 + 2N + ROUNDS*N + 2N cycles to done. Each stall cycle adds exactly one.
- Internal bit counter wraps at N-1. Counters are never left out of range; counters do not advance on stalled cycles.
- No fresh randomness is consumed; uniformity depends on the input sharing.

Test Plan:
1. N=16, ROUNDS=32 (Simon32/64); key 1918 1110 0908 0100, pt 6565 6877; b=c=0 shares, bench-supplied round keys, no stalls -> ct a^b^c = c69b e9bb; done exactly 1+32+512+32 cycles after start.
2. Same vector, random 3-way plaintext and key sharing, 50 runs -> recombined ct = c69b e9bb every run; ct_a alone differs from ct in >40 runs.
3. N=64, ROUNDS=68 (Simon128/128); key 0f0e0d0c0b0a0908 0706050403020100, pt 6373656420737265 6c6c657661727420; key_valid randomly low 30% -> ct 49681b1e1e54fe3f 65aa832af84e0bbc; cycle count = nominal + number of stall cycles.
4. ct_ready low for 5 cycles at unload bit 7, din_valid low for 3 cycles mid-LOAD -> ct bits held unchanged, no dropped or duplicated bits, correct ct; done only on the 2N-th accepted bit.
5. rst_n=0 for one cycle during RUN at round_idx=10 -> next cycle busy=0, ct_valid=0, round_idx=0, key_ready=0; a following full operation yields the correct ct.
6. start pulsed during LOAD, RUN and UNLOAD -> ignored. start held high through done -> a new LOAD begins in the cycle after the first IDLE cycle.

Source files
------------

// File: rtl/simon_ti3_serial_core_if.sv
// simon_ti3_serial_core_if: share streams and status between the TI Simon core and its neighbours
// start; din_{a,b,c}/din_valid/din_ready; key_{a,b,c}/key_valid/key_ready; ct_{a,b,c}/ct_valid/ct_ready; busy, done, round_idx
interface simon_ti3_serial_core_if #(
  parameter int RW = 7
);
  logic          start;
  logic          din_a, din_b, din_c, din_valid, din_ready;
  logic          key_a, key_b, key_c, key_valid, key_ready;
  logic          ct_a, ct_b, ct_c, ct_valid, ct_ready;
  logic          busy, done;
  logic [RW-1:0] round_idx;
  modport master (
    output start, din_a, din_b, din_c, din_valid, key_a, key_b, key_c, key_valid, ct_ready,
    input  din_ready, key_ready, ct_a, ct_b, ct_c, ct_valid, busy, done, round_idx
  );
  modport slave (
    input  start, din_a, din_b, din_c, din_valid, key_a, key_b, key_c, key_valid, ct_ready,
    output din_ready, key_ready, ct_a, ct_b, ct_c, ct_valid, busy, done, round_idx
  );
endinterface

// File: rtl/simon_ti3_serial_core.sv
// simon_ti3_serial_core: 3-share threshold-implementation bit-serial Simon core with load/run/unload control
// clk; rst_n (synchronous, active-low); bus (slave): plaintext shares in, round-key shares in,
// ciphertext shares out, each 1 bit/cycle with valid/ready; busy, done, round_idx status
module simon_ti3_serial_core #(
  parameter int N      = 64,
  parameter int ROUNDS = 68,
  parameter int RW     = $clog2(ROUNDS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  simon_ti3_serial_core_if.slave bus
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              hi_q, hi_d;
  logic [RW-1:0]     rnd_q, rnd_d;
  logic [2:0][N-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]        din, key, nb;
  logic              ld, st, ul, wrap, last_rnd;
  assign din      = {bus.din_c, bus.din_b, bus.din_a};
  assign key      = {bus.key_c, bus.key_b, bus.key_a};
  assign ld       = (state_q == LOAD) && bus.din_valid;
  assign st       = (state_q == RUN) && bus.key_valid;
  assign ul       = (state_q == UNLOAD) && bus.ct_ready;
  assign wrap     = cnt_q == CW'(N - 1);
  assign last_rnd = rnd_q == RW'(ROUNDS - 1);
  // x rotates right once per step, so taps N-1, N-2, N-8 always hold pre-round x[i-1], x[i-2], x[i-8];
  // share s only sees shares s+1 and s+2, keeping the sharing non-complete
  for (genvar s = 0; s < 3; s++) begin : g_ti
    localparam int P = (s + 1) % 3;
    localparam int Q = (s + 2) % 3;
    assign nb[s] = y_q[P][0] ^ key[P] ^ x_q[P][N-2]
                 ^ (x_q[P][N-1] & x_q[P][N-8])
                 ^ (x_q[P][N-1] & x_q[Q][N-8])
                 ^ (x_q[Q][N-1] & x_q[P][N-8]);
  end
  // new-x bits stream into y (whose bits are consumed in the same order); at round end the two swap
  always_comb begin
    state_d = state_q;
    cnt_d   = (ld || st || ul) ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
    hi_d    = ((ld || ul) && wrap) ? !hi_q : hi_q;
    rnd_d   = rnd_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: state_d = bus.start ? LOAD : IDLE;
      LOAD, UNLOAD: if (ld || ul) begin
        for (int s = 0; s < 3; s++) {x_d[s], y_d[s]} = {ld & din[s], x_q[s], y_q[s][N-1:1]};
        if (wrap && hi_q) state_d = ld ? RUN : IDLE;
      end
      RUN: if (st) begin
        for (int s = 0; s < 3; s++) begin
          x_d[s] = wrap ? {nb[s], y_q[s][N-1:1]} : {x_q[s][0], x_q[s][N-1:1]};
          y_d[s] = wrap ? {x_q[s][0], x_q[s][N-1:1]} : {nb[s], y_q[s][N-1:1]};
        end
        if (wrap) begin
          rnd_d   = last_rnd ? '0 : rnd_q + 1'b1;
          state_d = last_rnd ? UNLOAD : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      rnd_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      rnd_q   <= rnd_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end
  assign bus.din_ready = state_q == LOAD;
  assign bus.key_ready = state_q == RUN;
  assign bus.ct_valid  = state_q == UNLOAD;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = ul && wrap && hi_q;
  assign bus.round_idx = rnd_q;
  assign bus.ct_a      = bus.ct_valid & y_q[0][0];
  assign bus.ct_b      = bus.ct_valid & y_q[1][0];
  assign bus.ct_c      = bus.ct_valid & y_q[2][0];
endmodule

// File: tb/tb_simon_ti3_serial_core.sv
// tb_simon_ti3_serial_core: directed checks of the TI Simon core for Simon32/64 and Simon128/128
module tb_simon_ti3_serial_core;
  logic        clk = 1'b0;
  logic        rst_n, start, sel, din_valid, key_valid, ct_ready;
  logic [2:0]  din, key, ct;
  logic        din_ready, key_ready, ct_valid, busy, done;
  logic [6:0]  ridx;
  logic [63:0] rk [68];
  logic [63:0] kb [68];
  logic [63:0] kc [68];
  logic [0:61] z0, z2;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  simon_ti3_serial_core_if #(.RW(5)) i16 ();
  simon_ti3_serial_core_if #(.RW(7)) i64 ();
  simon_ti3_serial_core #(.N(16), .ROUNDS(32), .RW(5)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));
  simon_ti3_serial_core #(.N(64), .ROUNDS(68), .RW(7)) u64 (.clk(clk), .rst_n(rst_n), .bus(i64));
  assign i16.start = start && !sel;
  assign i64.start = start && sel;
  assign i16.din_a = din[0];
  assign i16.din_b = din[1];
  assign i16.din_c = din[2];
  assign i64.din_a = din[0];
  assign i64.din_b = din[1];
  assign i64.din_c = din[2];
  assign i16.key_a = key[0];
  assign i16.key_b = key[1];
  assign i16.key_c = key[2];
  assign i64.key_a = key[0];
  assign i64.key_b = key[1];
  assign i64.key_c = key[2];
  assign i16.din_valid = din_valid;
  assign i64.din_valid = din_valid;
  assign i16.key_valid = key_valid;
  assign i64.key_valid = key_valid;
  assign i16.ct_ready  = ct_ready;
  assign i64.ct_ready  = ct_ready;
  assign din_ready = sel ? i64.din_ready : i16.din_ready;
  assign key_ready = sel ? i64.key_ready : i16.key_ready;
  assign ct_valid  = sel ? i64.ct_valid : i16.ct_valid;
  assign busy      = sel ? i64.busy : i16.busy;
  assign done      = sel ? i64.done : i16.done;
  assign ct        = sel ? {i64.ct_c, i64.ct_b, i64.ct_a} : {i16.ct_c, i16.ct_b, i16.ct_a};
  assign ridx      = sel ? i64.round_idx : {2'b00, i16.round_idx};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] v, input int r, input int n);
    logic [63:0] m;
    m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    return ((v >> r) | (v << (n - r))) & m;
  endfunction

  task automatic expand(input int n, input int m, input int rounds, input logic [127:0] k, input bit use_z2);
    logic [63:0] msk, t;
    logic [0:61] z;
    msk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    z = use_z2 ? z2 : z0;
    for (int i = 0; i < m; i++) rk[i] = 64'(k >> (i * n)) & msk;
    for (int i = m; i < rounds; i++) begin
      t = ror(rk[i-1], 3, n);
      if (m == 4) t ^= rk[i-3];
      t ^= ror(t, 1, n);
      rk[i] = (~rk[i-m] & msk) ^ t ^ 64'(z[(i - m) % 62]) ^ 64'd3;
    end
  endtask

  // sm: 0 start pulse only, 1 extra start pulses in LOAD/RUN/UNLOAD, 2 start held high throughout
  task automatic op(input int n, input int rounds, input logic [127:0] pt, input bit shr, input int kst,
                    input bit st4, input int sm, input int abort_r,
                    output logic [127:0] ctw, output logic [127:0] cta, output int cyc, output int stl);
    logic [127:0] pa, pb, pc;
    logic [63:0]  msk;
    logic [2:0]   cth;
    int           li, ui, ri, bi, dh, ch;
    bit           fin, ab, acc;
    msk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    pb = shr ? {$urandom, $urandom, $urandom, $urandom} : '0;
    pc = shr ? {$urandom, $urandom, $urandom, $urandom} : '0;
    pa = pt ^ pb ^ pc;
    for (int r = 0; r < rounds; r++) begin
      kb[r] = shr ? ({$urandom, $urandom} & msk) : '0;
      kc[r] = shr ? ({$urandom, $urandom} & msk) : '0;
    end
    ctw = '0; cta = '0; cth = '0;
    li = 0; ui = 0; ri = 0; bi = 0; dh = 0; ch = 0; stl = 0;
    fin = 0; ab = 0;
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (!fin && cyc < 20000) begin
      cyc++;
      din_valid = 0; key_valid = 0; ct_ready = 0;
      start = (sm == 2) || (sm == 1 && (li == 3 || (key_ready && ri == 1 && bi == 0) || ui == 3));
      if (abort_r >= 0 && key_ready && int'(ridx) == abort_r) begin
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("abort_busy", busy, 0);
        chk("abort_ct_valid", ct_valid, 0);
        chk("abort_round_idx", ridx, 0);
        chk("abort_key_ready", key_ready, 0);
        ab = 1; fin = 1;
      end else begin
        if (din_ready) begin
          if (st4 && li == n / 2 && dh < 3) begin dh++; stl++; end
          else begin din_valid = 1; din = {pc[li], pb[li], pa[li]}; li++; end
        end
        if (key_ready) begin
          if (kst > 0 && $urandom_range(99) < kst) stl++;
          else begin
            key_valid = 1;
            key = {kc[ri][bi], kb[ri][bi], rk[ri][bi] ^ kb[ri][bi] ^ kc[ri][bi]};
            bi++;
            if (bi == n) begin bi = 0; ri++; end
          end
        end
        if (ct_valid) begin
          if (st4 && ui == 7 && ch < 5) begin ch++; stl++; end
          else ct_ready = 1;
        end
        #1;
        if (ct_valid && !ct_ready) begin
          if (ch == 1) cth = ct;
          else chk("ct_hold", ct, cth);
        end
        acc = ct_valid && ct_ready;
        if (acc) begin ctw[ui] = ^ct; cta[ui] = ct[0]; ui++; end
        if (acc || done) chk("done_pulse", done, acc && ui == 2 * n);
        fin = done;
        @(posedge clk); #1;
      end
    end
    din_valid = 0; key_valid = 0; ct_ready = 0;
    if (abort_r >= 0) chk("abort_reached", ab, 1);
    else chk("op_finished", fin, 1);
  endtask

  initial begin
    logic [127:0] ctw, cta;
    int cyc, stl, diff;
    z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    rst_n = 0; sel = 0; start = 0; din = '0; key = '0;
    din_valid = 0; key_valid = 0; ct_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ct_valid", ct_valid, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_ct", ct, 0);
    chk("rst_round_idx", ridx, 0);
    sel = 1; #1;
    chk("rst64_busy", busy, 0);
    chk("rst64_ct_valid", ct_valid, 0);
    chk("rst64_round_idx", ridx, 0);
    sel = 0; rst_n = 1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    expand(16, 4, 32, 128'h1918111009080100, 0);
    op(16, 32, 128'h65656877, 0, 0, 0, 0, -1, ctw, cta, cyc, stl);
    chk("t1_ct", ctw, 128'hc69be9bb);
    chk("t1_cycles", cyc, 577);

    diff = 0;
    for (int r = 0; r < 50; r++) begin
      op(16, 32, 128'h65656877, 1, 0, 0, 0, -1, ctw, cta, cyc, stl);
      chk("t2_ct", ctw, 128'hc69be9bb);
      if (cta != ctw) diff++;
    end
    chk("t2_share_a_differs", diff > 40, 1);

    sel = 1;
    expand(64, 2, 68, 128'h0f0e0d0c0b0a09080706050403020100, 1);
    op(64, 68, 128'h63736564207372656c6c657661727420, 1, 30, 0, 0, -1, ctw, cta, cyc, stl);
    chk("t3_ct", ctw, 128'h49681b1e1e54fe3f65aa832af84e0bbc);
    chk("t3_cycles", cyc, 1 + 256 + 68 * 64 + stl);
    sel = 0;

    expand(16, 4, 32, 128'h1918111009080100, 0);
    op(16, 32, 128'h65656877, 1, 0, 1, 0, -1, ctw, cta, cyc, stl);
    chk("t4_ct", ctw, 128'hc69be9bb);
    chk("t4_stalls", stl, 8);
    chk("t4_cycles", cyc, 577 + stl);

    op(16, 32, 128'h65656877, 1, 0, 0, 0, 10, ctw, cta, cyc, stl);
    op(16, 32, 128'h65656877, 1, 0, 0, 0, -1, ctw, cta, cyc, stl);
    chk("t5_ct", ctw, 128'hc69be9bb);
    chk("t5_cycles", cyc, 577);

    op(16, 32, 128'h65656877, 0, 0, 0, 1, -1, ctw, cta, cyc, stl);
    chk("t6_poke_ct", ctw, 128'hc69be9bb);
    chk("t6_poke_cycles", cyc, 577);
    op(16, 32, 128'h65656877, 1, 0, 0, 2, -1, ctw, cta, cyc, stl);
    chk("t6_hold_ct", ctw, 128'hc69be9bb);
    chk("t6_hold_cycles", cyc, 577);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_din_ready", din_ready, 0);
    @(posedge clk); #1;
    chk("t6_reload_din_ready", din_ready, 1);
    chk("t6_reload_busy", busy, 1);
    start = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("t6_rst_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
